// File: rtl/mac_dot_sequencer.sv
// mac_dot_sequencer: feeds one LEN-element activation/weight vector pair to a
// single-lane MAC one element at a time, chaining each MAC result back in as
// the next psum operand, and returns the finished dot product over valid/ready.
// psum persists between vectors so successive vectors can keep accumulating.

module mac_dot_sequencer #(
    parameter int unsigned bw      = 4,
    parameter int unsigned psum_bw = 16,
    parameter int unsigned LEN     = 4,
    parameter int unsigned MAC_LAT = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_clear,
    input  logic [LEN*bw-1:0]     in_x,
    input  logic [LEN*bw-1:0]     in_w,
    output logic [bw-1:0]         mac_a,
    output logic [bw-1:0]         mac_b,
    output logic [psum_bw-1:0]    mac_c,
    input  logic [psum_bw-1:0]    mac_out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [psum_bw-1:0]    out_psum
);

    localparam int unsigned KW       = (LEN > 1) ? $clog2(LEN) : 1;
    localparam int unsigned CW       = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
    // Guarded so the WAIT compare still elaborates when MAC_LAT is 0
    localparam int unsigned LAT_LAST = (MAC_LAT > 0) ? MAC_LAT - 1 : 0;
    localparam int unsigned K_LAST   = LEN - 1;

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

    state_e               state_q, state_d;
    logic [KW-1:0]        k_q, k_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [psum_bw-1:0]   psum_q, psum_d;
    logic [bw-1:0]        x_q [LEN];
    logic [bw-1:0]        x_d [LEN];
    logic [bw-1:0]        w_q [LEN];
    logic [bw-1:0]        w_d [LEN];
    logic                 advance;

    // Next-state, datapath capture and output decode
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        cnt_d     = cnt_q;
        psum_d    = psum_q;
        x_d       = x_q;
        w_d       = w_q;
        advance   = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        mac_a     = '0;
        mac_b     = '0;
        mac_c     = psum_q;
        out_psum  = psum_q;

        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    for (int i = 0; i < int'(LEN); i++) begin
                        x_d[i] = in_x[i*bw +: bw];
                        w_d[i] = in_w[i*bw +: bw];
                    end
                    if (in_clear) begin
                        psum_d = '0;
                    end
                    k_d     = '0;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                mac_a = x_q[k_q];
                mac_b = w_q[k_q];
                cnt_d = '0;
                if (MAC_LAT == 0) begin
                    // Combinational MAC: result is already valid this cycle
                    psum_d  = mac_out;
                    advance = 1'b1;
                end else begin
                    state_d = StWait;
                end
            end
            StWait: begin
                mac_a = x_q[k_q];
                mac_b = w_q[k_q];
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(LAT_LAST)) begin
                    psum_d  = mac_out;
                    advance = 1'b1;
                end
            end
            StDone: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Element finished: move to the next one or hand the result out
        if (advance) begin
            if (k_q == KW'(K_LAST)) begin
                state_d = StDone;
            end else begin
                k_d     = k_q + 1'b1;
                state_d = StIssue;
            end
        end
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= StIdle;
            k_q     <= '0;
            cnt_q   <= '0;
            psum_q  <= '0;
            for (int i = 0; i < int'(LEN); i++) begin
                x_q[i] <= '0;
                w_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            psum_q  <= psum_d;
            for (int i = 0; i < int'(LEN); i++) begin
                x_q[i] <= x_d[i];
                w_q[i] <= w_d[i];
            end
        end
    end

endmodule

// File: tb/tb_mac_dot_sequencer.sv
// Bench for mac_dot_sequencer: three instances with MAC latencies 0, 1 and 3,
// each driven by its own behavioural MAC, driver and scoreboard monitor.

module tb_mac_dot_sequencer;

    localparam int unsigned BW  = 4;
    localparam int unsigned PW  = 16;
    localparam int unsigned LEN = 4;
    localparam int          NL  = 3;

    typedef logic [LEN*BW-1:0] vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec    = 0;
    int n_err    = 0;
    int done_cnt = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t pk(int e0, int e1, int e2, int e3);
        return {BW'(e3), BW'(e2), BW'(e1), BW'(e0)};
    endfunction

    for (genvar g = 0; g < NL; g++) begin : lane
        localparam int LAT = (g == 0) ? 0 : ((g == 1) ? 1 : 3);

        logic          reset_n, in_valid, in_ready, in_clear;
        logic          out_valid, out_ready;
        vec_t          in_x, in_w;
        logic [BW-1:0] mac_a, mac_b;
        logic [PW-1:0] mac_c, mac_out, out_psum;
        logic [PW-1:0] pipe [4];

        // Behavioural MAC: c + unsigned a * signed b, wrapping at PW bits
        function automatic logic [PW-1:0] mac_f(logic [BW-1:0] a, logic [BW-1:0] b,
                                               logic [PW-1:0] c);
            int p;
            p = int'(a) * int'($signed(b));
            return c + PW'(p);
        endfunction

        always @(posedge clk) begin
            pipe[0] <= mac_f(mac_a, mac_b, mac_c);
            for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
        end
        assign mac_out = (LAT == 0) ? mac_f(mac_a, mac_b, mac_c) : pipe[(LAT == 0) ? 0 : LAT-1];

        mac_dot_sequencer #(
            .bw      (BW),
            .psum_bw (PW),
            .LEN     (LEN),
            .MAC_LAT (LAT)
        ) dut (
            .clk       (clk),
            .reset_n   (reset_n),
            .in_valid  (in_valid),
            .in_ready  (in_ready),
            .in_clear  (in_clear),
            .in_x      (in_x),
            .in_w      (in_w),
            .mac_a     (mac_a),
            .mac_b     (mac_b),
            .mac_c     (mac_c),
            .mac_out   (mac_out),
            .out_valid (out_valid),
            .out_ready (out_ready),
            .out_psum  (out_psum)
        );

        logic [PW-1:0] exp_q [$];
        int            acc_q [$];
        int            bp_q  [$];
        logic [PW-1:0] ref_psum;
        bit            drv_done = 1'b0;

        task automatic reset_state(string tag);
            check($sformatf("L%0d %s in_ready", LAT, tag), 32'(in_ready), 32'd1);
            check($sformatf("L%0d %s out_valid", LAT, tag), 32'(out_valid), 32'd0);
            check($sformatf("L%0d %s mac_a", LAT, tag), 32'(mac_a), 32'd0);
            check($sformatf("L%0d %s mac_b", LAT, tag), 32'(mac_b), 32'd0);
            check($sformatf("L%0d %s mac_c", LAT, tag), 32'(mac_c), 32'd0);
            check($sformatf("L%0d %s out_psum", LAT, tag), 32'(out_psum), 32'd0);
        endtask

        // Called at a negedge. abort_el >= 0 resets the DUT during that element.
        task automatic send(bit clr, vec_t x, vec_t w, int bp, int abort_el);
            logic [PW-1:0] pre [LEN+1];
            int t;
            int k;
            pre[0] = clr ? '0 : ref_psum;
            for (int i = 0; i < int'(LEN); i++) begin
                pre[i+1] = pre[i] + PW'(int'(x[i*BW +: BW]) * int'($signed(w[i*BW +: BW])));
            end
            in_x     = x;
            in_w     = w;
            in_clear = clr;
            in_valid = 1'b1;
            t = 0;
            while (!in_ready && t < 200) begin
                @(negedge clk);
                t++;
            end
            if (!in_ready) begin
                check($sformatf("L%0d accept timeout", LAT), 32'(in_ready), 32'd1);
                in_valid = 1'b0;
                return;
            end
            if (abort_el < 0) begin
                exp_q.push_back(pre[LEN]);
                acc_q.push_back(cyc + 1);
                bp_q.push_back(bp);
                ref_psum = pre[LEN];
            end
            @(negedge clk);
            in_valid = 1'b0;
            in_x     = vec_t'($urandom);
            in_w     = vec_t'($urandom);
            in_clear = 1'($urandom);
            for (int s = 0; s < int'(LEN) * (LAT + 1); s++) begin
                k = s / (LAT + 1);
                if (k == abort_el) begin
                    reset_n = 1'b0;
                    @(negedge clk);
                    reset_n = 1'b1;
                    reset_state("abort");
                    ref_psum = '0;
                    return;
                end
                check($sformatf("L%0d mac_a s%0d", LAT, s), 32'(mac_a), 32'(x[k*BW +: BW]));
                check($sformatf("L%0d mac_b s%0d", LAT, s), 32'(mac_b), 32'(w[k*BW +: BW]));
                check($sformatf("L%0d mac_c s%0d", LAT, s), 32'(mac_c), 32'(pre[k]));
                @(negedge clk);
            end
        endtask

        // Driver
        initial begin
            reset_n  = 1'b0;
            in_valid = 1'b0;
            in_clear = 1'b0;
            in_x     = '0;
            in_w     = '0;
            ref_psum = '0;
            repeat (2) @(negedge clk);
            reset_n = 1'b1;
            reset_state("reset");
            send(1'b1, pk(1, 2, 3, 4), pk(1, 15, 2, 14), 5, -1);
            send(1'b0, pk(15, 15, 15, 15), pk(7, 7, 7, 7), 0, -1);
            send(1'b0, pk(0, 0, 0, 0), pk(5, 9, 3, 1), 1, -1);
            send(1'b1, pk(1, 2, 3, 4), pk(1, 15, 2, 14), 0, -1);
            send(1'b0, pk(1, 1, 1, 1), pk(1, 1, 1, 1), 2, -1);
            send(1'b1, pk(5, 5, 5, 5), pk(1, 1, 1, 1), 0, 2);
            send(1'b0, pk(2, 2, 2, 2), pk(3, 3, 3, 3), 0, -1);
            repeat (20) begin
                send(1'($urandom), vec_t'($urandom), vec_t'($urandom),
                     int'($urandom_range(0, 4)), -1);
            end
            drv_done = 1'b1;
        end

        // Monitor / consumer
        initial begin
            logic [PW-1:0] e;
            int a;
            int bp;
            int idle;
            out_ready = 1'b0;
            idle = 0;
            forever begin
                @(negedge clk);
                if (drv_done && exp_q.size() == 0) break;
                if (out_valid) begin
                    if (exp_q.size() == 0) begin
                        check($sformatf("L%0d unexpected out_valid", LAT), 32'(out_valid), 32'd0);
                        e = out_psum;
                        a = cyc - LEN * (LAT + 1);
                        bp = 0;
                    end else begin
                        e = exp_q.pop_front();
                        a = acc_q.pop_front();
                        bp = bp_q.pop_front();
                    end
                    check($sformatf("L%0d out_psum", LAT), 32'(out_psum), 32'(e));
                    check($sformatf("L%0d latency", LAT), 32'(cyc - a), 32'(LEN * (LAT + 1)));
                    repeat (bp) begin
                        @(negedge clk);
                        check($sformatf("L%0d hold out_valid", LAT), 32'(out_valid), 32'd1);
                        check($sformatf("L%0d hold out_psum", LAT), 32'(out_psum), 32'(e));
                        check($sformatf("L%0d hold in_ready", LAT), 32'(in_ready), 32'd0);
                    end
                    out_ready = 1'b1;
                    @(negedge clk);
                    out_ready = 1'b0;
                    check($sformatf("L%0d release out_valid", LAT), 32'(out_valid), 32'd0);
                    check($sformatf("L%0d release in_ready", LAT), 32'(in_ready), 32'd1);
                    check($sformatf("L%0d persist psum", LAT), 32'(out_psum), 32'(e));
                    idle = 0;
                end else if (exp_q.size() != 0) begin
                    idle++;
                    if (idle > 100) begin
                        check($sformatf("L%0d out_valid timeout", LAT), 32'(out_valid), 32'd1);
                        void'(exp_q.pop_front());
                        void'(acc_q.pop_front());
                        void'(bp_q.pop_front());
                        idle = 0;
                    end
                end
            end
            done_cnt++;
        end
    end

    initial begin
        int t;
        t = 0;
        while (done_cnt < NL && t < 50000) begin
            @(negedge clk);
            t++;
        end
        if (done_cnt < NL) begin
            check("global timeout", 32'(done_cnt), 32'(NL));
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
